// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: accepts register-form instructions, reads operands from an
// 8x8 register file, sequences one ALU operation (setup / fire / capture) and
// writes the result back. LDI and illegal opcodes bypass the ALU.
module alu_issue_ctrl #(
  parameter int unsigned NREG = 8,
  parameter int unsigned DW   = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [15:0]   instr,
  output logic          alu_enable,
  output logic [3:0]    alu_fn_sel,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  input  logic [DW-1:0] alu_out,
  output logic          alu_cmpflag,
  output logic          done,
  output logic          err,
  output logic          eq_flag,
  input  logic [2:0]    dbg_addr,
  output logic [DW-1:0] dbg_data
);

  localparam int unsigned OPW = 4;
  localparam int unsigned AW  = 3;

  localparam logic [OPW-1:0] OP_DEC = 4'd6;
  localparam logic [OPW-1:0] OP_INC = 4'd7;
  localparam logic [OPW-1:0] OP_CMP = 4'd8;
  localparam logic [OPW-1:0] OP_LDI = 4'd9;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    FIRE    = 3'd2,
    CAPTURE = 3'd3,
    WB      = 3'd4
  } state_t;

  state_t          state;
  logic [DW-1:0]   regs [NREG];
  logic [OPW-1:0]  op_q;
  logic [AW-1:0]   rd_q;
  logic [DW-1:0]   imm_q;
  logic [DW-1:0]   res_q;

  logic [OPW-1:0]  op_c;
  logic [AW-1:0]   rd_c;
  logic [AW-1:0]   rs1_c;
  logic [AW-1:0]   rs2_c;
  logic            accept_c;

  // Instruction field decode
  assign op_c     = instr[15:12];
  assign rd_c     = instr[11:9];
  assign rs1_c    = instr[8:6];
  assign rs2_c    = instr[5:3];
  assign accept_c = instr_valid && instr_ready;

  // Debug read port of the register file
  assign dbg_data = regs[dbg_addr];

  // Issue sequencer: state, register file and all registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      instr_ready <= 1'b1;
      alu_enable  <= 1'b0;
      alu_fn_sel  <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_cmpflag <= 1'b1;
      done        <= 1'b0;
      err         <= 1'b0;
      eq_flag     <= 1'b0;
      op_q        <= '0;
      rd_q        <= '0;
      imm_q       <= '0;
      res_q       <= '0;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (accept_c) begin
            op_q        <= op_c;
            rd_q        <= rd_c;
            imm_q       <= DW'(instr[7:0]);
            instr_ready <= 1'b0;
            if (op_c <= OP_CMP) begin
              alu_a       <= regs[rs1_c];
              alu_b       <= (op_c == OP_DEC || op_c == OP_INC) ? '0 : regs[rs2_c];
              alu_fn_sel  <= (op_c == OP_CMP) ? 4'd1 : op_c;
              alu_cmpflag <= !((op_c == OP_CMP) && (regs[rs1_c] == regs[rs2_c]));
              state       <= SETUP;
            end else begin
              // LDI or illegal: straight to writeback, retire next cycle
              done  <= 1'b1;
              err   <= (op_c != OP_LDI);
              state <= WB;
            end
          end
        end
        SETUP: begin
          alu_enable <= 1'b1;
          state      <= FIRE;
        end
        FIRE: begin
          alu_enable <= 1'b0;
          state      <= CAPTURE;
        end
        CAPTURE: begin
          res_q       <= alu_out;
          alu_cmpflag <= 1'b1;
          done        <= 1'b1;
          state       <= WB;
        end
        WB: begin
          if (op_q < OP_CMP) begin
            regs[rd_q] <= res_q;
          end else if (op_q == OP_CMP) begin
            eq_flag <= (res_q == '0);
          end else if (op_q == OP_LDI) begin
            regs[rd_q] <= imm_q;
          end
          instr_ready <= 1'b1;
          state       <= IDLE;
        end
        default: begin
          instr_ready <= 1'b1;
          alu_enable  <= 1'b0;
          alu_cmpflag <= 1'b1;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural ALU driven by alu_enable.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic        alu_enable;
  logic [3:0]  alu_fn_sel;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [7:0]  alu_out;
  logic        alu_cmpflag;
  logic        done;
  logic        err;
  logic        eq_flag;
  logic [2:0]  dbg_addr;
  logic [7:0]  dbg_data;

  int checks = 0;
  int errors = 0;

  alu_issue_ctrl #(.NREG(8), .DW(8)) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .alu_enable(alu_enable), .alu_fn_sel(alu_fn_sel), .alu_a(alu_a),
    .alu_b(alu_b), .alu_out(alu_out), .alu_cmpflag(alu_cmpflag), .done(done),
    .err(err), .eq_flag(eq_flag), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: evaluates on the rising edge of alu_enable
  initial alu_out = 8'h00;
  always @(posedge alu_enable) begin
    case (alu_fn_sel)
      4'd0: alu_out <= 8'(alu_a + alu_b);
      4'd1: alu_out <= 8'(alu_a - alu_b);
      4'd2: alu_out <= alu_a & alu_b;
      4'd3: alu_out <= alu_a | alu_b;
      4'd4: alu_out <= 8'(alu_a << 1);
      4'd5: alu_out <= alu_a >> 1;
      4'd6: alu_out <= 8'(alu_a - 8'd1);
      4'd7: alu_out <= 8'(alu_a + 8'd1);
      default: alu_out <= 8'h00;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] enc(input int op, input int rd, input int rs1, input int rs2);
    enc = {4'(op), 3'(rd), 3'(rs1), 3'(rs2), 3'b000};
  endfunction

  function automatic logic [15:0] ldi(input int rd, input int imm);
    ldi = {4'd9, 3'(rd), 1'b0, 8'(imm)};
  endfunction

  task automatic rd_reg(input int addr, output logic [7:0] val);
    dbg_addr = 3'(addr);
    #1;
    val = dbg_data;
  endtask

  // Issue one instruction and observe it until retire; ends in IDLE
  task automatic run(input logic [15:0] ins, output int lat, output int ena, output int cmp0,
                     output logic stab, output logic [7:0] a0, output logic [7:0] b0,
                     output logic [3:0] f0, output logic err_seen);
    int n;
    @(negedge clk);
    instr = ins;
    instr_valid = 1'b1;
    n = 0;
    while (!instr_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!instr_ready) check("accept_timeout", 32'(instr_ready), 32'd1);
    @(negedge clk);
    instr_valid = 1'b0;
    lat = 1; ena = 0; cmp0 = 0; stab = 1'b1;
    a0 = alu_a; b0 = alu_b; f0 = alu_fn_sel;
    while (!done && lat < 20) begin
      ena += int'(alu_enable);
      cmp0 += int'(!alu_cmpflag);
      if (alu_a !== a0 || alu_b !== b0 || alu_fn_sel !== f0) stab = 1'b0;
      @(negedge clk);
      lat++;
    end
    if (!done) check("done_timeout", 32'(done), 32'd1);
    cmp0 += int'(!alu_cmpflag);
    err_seen = err;
    @(negedge clk);
  endtask

  initial begin
    int lat, ena, cmp0, n, dcnt;
    logic stab, es;
    logic [7:0] a0, b0, v;
    logic [3:0] f0;
    logic [6:0] rdy_v, done_v;

    reset = 1'b1; instr_valid = 1'b0; instr = 16'h0000; dbg_addr = 3'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset state
    check("rst_ready", 32'(instr_ready), 32'd1);
    check("rst_enable", 32'(alu_enable), 32'd0);
    check("rst_cmpflag", 32'(alu_cmpflag), 32'd1);
    check("rst_done_err", 32'({done, err, eq_flag}), 32'd0);
    check("rst_fn_a_b", 32'({alu_fn_sel, alu_a, alu_b}), 32'd0);
    rd_reg(0, v); check("rst_r0", 32'(v), 32'h00);

    // LDI r1,5 ; LDI r2,3 ; ADD r3,r1,r2
    run(ldi(1, 8'h05), lat, ena, cmp0, stab, a0, b0, f0, es);
    check("ldi_latency", 32'(lat), 32'd1);
    check("ldi_no_enable", 32'(ena), 32'd0);
    run(ldi(2, 8'h03), lat, ena, cmp0, stab, a0, b0, f0, es);
    run(enc(0, 3, 1, 2), lat, ena, cmp0, stab, a0, b0, f0, es);
    check("add_latency", 32'(lat), 32'd4);
    check("add_enable_cycles", 32'(ena), 32'd1);
    check("add_operands", 32'({f0, a0, b0}), 32'h0_05_03);
    check("add_stable", 32'(stab), 32'd1);
    check("add_cmpflag", 32'(cmp0), 32'd0);
    check("add_err", 32'(es), 32'd0);
    rd_reg(3, v); check("add_r3", 32'(v), 32'h08);

    // LDI r1,9 ; SUB r4,r1,r1 ; CMP r1,r1
    run(ldi(1, 8'h09), lat, ena, cmp0, stab, a0, b0, f0, es);
    run(enc(1, 4, 1, 1), lat, ena, cmp0, stab, a0, b0, f0, es);
    check("sub_fn", 32'(f0), 32'd1);
    check("sub_cmpflag", 32'(cmp0), 32'd0);
    rd_reg(4, v); check("sub_r4", 32'(v), 32'h00);
    check("sub_eq_untouched", 32'(eq_flag), 32'd0);
    run(enc(8, 1, 1, 1), lat, ena, cmp0, stab, a0, b0, f0, es);
    check("cmp_latency", 32'(lat), 32'd4);
    check("cmp_fn", 32'(f0), 32'd1);
    check("cmp_cmpflag_low_cycles", 32'(cmp0), 32'd3);
    check("cmp_eq", 32'(eq_flag), 32'd1);
    check("cmp_cmpflag_after", 32'(alu_cmpflag), 32'd1);
    rd_reg(1, v); check("cmp_r1_kept", 32'(v), 32'h09);

    // LDI r5,FF ; INC r5,r5 ; DEC r6,r5
    run(ldi(5, 8'hFF), lat, ena, cmp0, stab, a0, b0, f0, es);
    run(enc(7, 5, 5, 5), lat, ena, cmp0, stab, a0, b0, f0, es);
    check("inc_operands", 32'({f0, a0, b0}), 32'h7_FF_00);
    rd_reg(5, v); check("inc_wrap_r5", 32'(v), 32'h00);
    run(enc(6, 6, 5, 3), lat, ena, cmp0, stab, a0, b0, f0, es);
    check("dec_b_zero", 32'(b0), 32'h00);
    rd_reg(6, v); check("dec_wrap_r6", 32'(v), 32'hFF);

    // CMP of unequal operands
    run(enc(8, 0, 1, 6), lat, ena, cmp0, stab, a0, b0, f0, es);
    check("cmp_ne_cmpflag", 32'(cmp0), 32'd0);
    check("cmp_ne_eq", 32'(eq_flag), 32'd0);

    // Illegal opcode 0xC
    run(16'hC000 | enc(0, 1, 2, 3), lat, ena, cmp0, stab, a0, b0, f0, es);
    check("ill_latency", 32'(lat), 32'd1);
    check("ill_err", 32'(es), 32'd1);
    check("ill_no_enable", 32'(ena), 32'd0);
    check("ill_err_pulse", 32'(err), 32'd0);
    rd_reg(1, v); check("ill_r1", 32'(v), 32'h09);
    rd_reg(6, v); check("ill_r6", 32'(v), 32'hFF);

    // Back-to-back: ADD r7,r1,r6 held valid
    @(negedge clk);
    instr = enc(0, 7, 1, 6);
    instr_valid = 1'b1;
    rdy_v = '0; done_v = '0;
    rdy_v[0] = instr_ready; done_v[0] = done;
    for (int i = 1; i < 7; i++) begin
      @(negedge clk);
      rdy_v[i] = instr_ready;
      done_v[i] = done;
    end
    instr_valid = 1'b0;
    check("b2b_ready_pattern", 32'(rdy_v), 32'(7'b0100001));
    check("b2b_done_pattern", 32'(done_v), 32'(7'b0010000));
    n = 0;
    while (!done && n < 10) begin @(negedge clk); n++; end
    check("b2b_second_done", 32'(done), 32'd1);
    @(negedge clk);
    rd_reg(7, v); check("b2b_r7", 32'(v), 32'h08);

    // Reset during FIRE of ADD r3,r1,r2
    @(negedge clk);
    instr = enc(0, 3, 1, 2);
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    n = 0;
    while (!alu_enable && n < 10) begin @(negedge clk); n++; end
    check("rst_fire_reached", 32'(alu_enable), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_ready", 32'(instr_ready), 32'd1);
    check("mid_rst_enable", 32'(alu_enable), 32'd0);
    check("mid_rst_done", 32'({done, err}), 32'd0);
    rd_reg(3, v); check("mid_rst_r3", 32'(v), 32'h00);
    dcnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      dcnt += int'(done);
    end
    check("mid_rst_no_done", 32'(dcnt), 32'd0);
    run(ldi(2, 8'h3C), lat, ena, cmp0, stab, a0, b0, f0, es);
    check("post_rst_ldi_lat", 32'(lat), 32'd1);
    rd_reg(2, v); check("post_rst_r2", 32'(v), 32'h3C);
    rd_reg(1, v); check("post_rst_r1", 32'(v), 32'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Initiator side of the ALU operand/enable interface: accepts 16-bit register-form instructions over a valid/ready handshake and reads operands from an internal 8x8-bit register file.
- Drives fn_sel/a/b and a single enable pulse into the ALU, captures its 8-bit result and writes it back.
- Sits between the instruction fetch stage and the ALU in the microprocessor datapath.

Parameters:
- NREG, 8, number of general registers (address width 3 bits, fixed).
- DW, 8, data width; must equal the ALU operand width.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- instr_valid  input  1  instruction present on instr.
- instr_ready  output  1  high only in IDLE; transfer occurs when instr_valid && instr_ready at a clk edge.
- instr  input  16  [15:12] opcode, [11:9] rd, [8:6] rs1, [5:3] rs2, [7:0] imm (LDI only).
- alu_enable  output  1  ALU trigger; the ALU acts on its rising edge.
- alu_fn_sel  output  4  ALU function select.
- alu_a  output  8  ALU operand a.
- alu_b  output  8  ALU operand b.
- alu_out  input  8  ALU result.
- alu_cmpflag  output  1  ALU compare input; 0 forces the ALU zero flag.
- done  output  1  one-cycle pulse at instruction retire.
- err  output  1  one-cycle pulse with done for an illegal opcode.
- eq_flag  output  1  result of the last CMP (1 = operands equal).
- dbg_addr  input  3  debug register-file read address.
- dbg_data  output  8  combinational read of reg[dbg_addr].

Behaviour:
- Reset values: state=IDLE; all registers 0; instr_ready=1; alu_enable=0; alu_fn_sel=0; alu_a=0; alu_b=0; alu_cmpflag=1; done=0; err=0; eq_flag=0.
- Opcodes: 0..7 are ALU ops issued with fn_sel=opcode (ADD, SUB, AND, OR, SHL, SHR, DEC, INC). 8 is CMP (fn_sel=1, no writeback). 9 is LDI (rd<=imm, no ALU). 10..15 are illegal.
- FSM states: IDLE, SETUP, FIRE, CAPTURE, WB.
- IDLE, on accept of ALU/CMP opcode:
  - Latch rd and opcode.
  - alu_a<=reg[rs1]; alu_b<=reg[rs2], or 0 for DEC/INC.
  - alu_fn_sel per opcode; go to SETUP.
- IDLE, on accept of LDI or an illegal opcode: go to WB.
- SETUP: alu_enable=0 and operands stable, giving a full cycle of setup before the trigger; go to FIRE.
- FIRE: alu_enable=1 for exactly one cycle; go to CAPTURE.
- CAPTURE: alu_enable=0; alu_out sampled into a result register at the end of the cycle; go to WB.
- WB:
  - ALU op: reg[rd]<=result.
  - CMP: eq_flag<=(result==0); no write.
  - LDI: reg[rd]<=imm.
  - Illegal opcode: no write; err=1.
  - done=1 in all cases; go to IDLE.
- alu_cmpflag:
  - 1 at all times except SETUP, FIRE and CAPTURE of a CMP whose latched alu_a==alu_b; it is 0 then.
  - Never 0 for non-CMP ops.
- Latency, accept edge to done:
  - ALU/CMP: done high in the 4th cycle after accept (SETUP, FIRE, CAPTURE, WB).
  - LDI/illegal: done high in the 1st cycle after accept.
  - Throughput: next accept no earlier than the cycle after WB.
- alu_fn_sel, alu_a and alu_b hold their values from SETUP through CAPTURE and keep their last values in IDLE/WB.
- Arithmetic: results are the ALU's 8-bit out, written unmodified. Wrap-around (INC 0xFF gives 0x00, DEC 0x00 gives 0xFF) is the ALU's behaviour and is written as-is.
- Hazards: none possible; writeback completes before the next accept.
  - rs1==rd or rs2==rd reads the pre-instruction value.
  - dbg_data reflects a WB write from the cycle after WB.
- instr_valid while busy: ignored (ready=0); the source holds the instruction.
- Reset mid-operation, any state:
  - Next edge returns to IDLE with alu_enable=0 and all registers cleared.
  - No done/err pulse; the pending writeback is discarded.
- reset has priority over an accept in the same cycle.

Test Plan:
- LDI r1,0x05; LDI r2,0x03; ADD r3,r1,r2 -> dbg r3=0x08; ADD done exactly 4 cycles after accept; alu_enable high exactly 1 cycle; fn_sel=0, a=0x05, b=0x03 stable SETUP..CAPTURE.
- LDI r1,0x09; SUB r4,r1,r1 then CMP r1,r1 -> r4=0x00; eq_flag=1; alu_cmpflag=0 only during the CMP's SETUP..CAPTURE; no register changed by CMP.
- LDI r5,0xFF; INC r5,r5 -> r5=0x00, alu_b=0. Then DEC r6,r5 -> r6=0xFF.
- Opcode 0xC with instr_valid held high -> err and done pulse 1 cycle after accept; no alu_enable pulse; all registers unchanged.
- Back-to-back instr_valid with ALU op -> instr_ready=0 during SETUP/FIRE/CAPTURE/WB; second instruction accepted the cycle after WB.
- Reset asserted during FIRE of ADD r3 -> next cycle IDLE, alu_enable=0, r3=0, no done; subsequent LDI executes normally.
